// File: rtl/seven_seg_scanner.sv
// Multiplexed 4-digit common-anode seven-segment driver with per-slot blanking and a double-buffered value.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module seven_seg_scanner #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        pending
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt;
  logic [1:0]    digit;
  logic [15:0]   pend_val;
  logic [3:0]    pend_dp;
  logic [15:0]   disp_val;
  logic [3:0]    disp_dp;
  logic          tick;
  logic          frame_end;
  logic          blank_phase;
  logic          show;
  logic [3:0]    cur_nib;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign tick        = (cnt == CNT_LAST);
  assign frame_end   = tick && (digit == 2'd3);
  assign blank_phase = (cnt < BLANK_END);
  assign cur_nib     = disp_val[{digit, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  logic [1:0] msd;

  always_comb begin
    msd = 2'd0;
    if (disp_val[15:12] != 4'h0)     msd = 2'd3;
    else if (disp_val[11:8] != 4'h0) msd = 2'd2;
    else if (disp_val[7:4] != 4'h0)  msd = 2'd1;
  end

  // Digit 0 always passes since msd never drops below 0.
  assign show = (digit <= msd);
`else
  assign show = 1'b1;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt   <= '0;
      digit <= 2'd0;
    end else if (tick) begin
      cnt   <= '0;
      digit <= digit + 2'd1;
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end

  // A load on the frame-boundary cycle lands in pending after the old contents move out.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pend_val <= 16'h0000;
      pend_dp  <= 4'h0;
      disp_val <= 16'h0000;
      disp_dp  <= 4'h0;
      pending  <= 1'b0;
    end else begin
      if (frame_end && pending) begin
        disp_val <= pend_val;
        disp_dp  <= pend_dp;
        pending  <= 1'b0;
      end
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_mask;
        pending  <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else if (blank_phase || !show) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << digit);
      seg <= hex7(cur_nib);
      dp  <= ~disp_dp[digit];
    end
  end

endmodule
